// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O responder: register offsets,
// access sizes, FSM states and the active-low seven-segment lookup.
package io_pkg;

  localparam logic [11:0] OFF_LEDR  = 12'h000;
  localparam logic [11:0] OFF_LEDG  = 12'h010;
  localparam logic [11:0] OFF_HEXLO = 12'h020;
  localparam logic [11:0] OFF_HEXHI = 12'h024;
  localparam logic [11:0] OFF_SW    = 12'h800;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven 0. Index 15 is first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/io_responder_if.sv
// LSU data-bus request/response channel between the core (master) and the I/O responder (slave).
// Both the request and the response use a valid/ready handshake.
interface io_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_addr;
  logic        i_wren;
  logic [31:0] i_wdata;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_addr, i_wren, i_wdata, i_size, i_unsigned, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_addr, i_wren, i_wdata, i_size, i_unsigned, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/hex_decoder.sv
// Combinational nibble to active-low seven-segment decoder (hex digits 0-F).
module hex_decoder
  import io_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/io_responder.sv
// 4 KiB I/O window target: LED/HEX registers, synchronized switches, one-cycle registered response
// that holds until consumed. IO_HEX_DECODE_EN stores HEX nibbles and drives decoded segments.
module io_responder
  import io_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h1000_0000,
  parameter int          LEDR_W  = 17,
  parameter int          LEDG_W  = 8,
  parameter int          SW_W    = 17
) (
  input  logic              i_clk,
  input  logic              i_reset,
  io_responder_if.slave     bus,
  input  logic [SW_W-1:0]   i_io_sw,
  output logic [LEDR_W-1:0] o_io_ledr,
  output logic [LEDG_W-1:0] o_io_ledg,
  output logic [6:0]        o_io_hex0,
  output logic [6:0]        o_io_hex1,
  output logic [6:0]        o_io_hex2,
  output logic [6:0]        o_io_hex3,
  output logic [6:0]        o_io_hex4,
  output logic [6:0]        o_io_hex5,
  output logic [6:0]        o_io_hex6,
  output logic [6:0]        o_io_hex7
);

`ifdef IO_HEX_DECODE_EN
  localparam logic [6:0] HEX_MASK = 7'h0F;
`else
  localparam logic [6:0] HEX_MASK = 7'h7F;
`endif

  state_e            state_q, state_d;
  logic [SW_W-1:0]   sw_meta, sw_sync;
  logic [LEDR_W-1:0] ledr_q;
  logic [LEDG_W-1:0] ledg_q;
  logic [6:0]        hex_q [8];
  logic [6:0]        hex_pins [8];
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic        accept;
  logic [11:0] word_off;
  logic        mapped;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wr_mask, wr_shift, rd_word, rd_shift, merged, load_data;

  assign bus.o_req_ready = (state_q == IDLE) || bus.i_rsp_ready;
  assign accept          = bus.i_req_valid && bus.o_req_ready;
  assign word_off        = {bus.i_addr[11:2], 2'b00};

  always_comb begin
    mapped = 1'b0;
    case (word_off)
      OFF_LEDR, OFF_LEDG, OFF_HEXLO, OFF_HEXHI, OFF_SW: mapped = 1'b1;
      default: mapped = 1'b0;
    endcase
  end

  assign err = (bus.i_addr[31:12] != IO_BASE[31:12]) || !mapped ||
               (bus.i_size == 2'b11) ||
               ((bus.i_size == SZ_HALF) && bus.i_addr[0]) ||
               ((bus.i_size == SZ_WORD) && (bus.i_addr[1:0] != 2'b00));

  always_comb begin
    be = 4'b1111;
    case (bus.i_size)
      SZ_BYTE: be = 4'b0001 << bus.i_addr[1:0];
      SZ_HALF: be = bus.i_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign wr_mask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_shift = bus.i_wdata << {bus.i_addr[1:0], 3'b000};

  always_comb begin
    rd_word = 32'h0;
    case (word_off)
      OFF_LEDR:  rd_word = 32'(ledr_q);
      OFF_LEDG:  rd_word = 32'(ledg_q);
      OFF_HEXLO: rd_word = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
      OFF_HEXHI: rd_word = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
      OFF_SW:    rd_word = 32'(sw_sync);
      default:   rd_word = 32'h0;
    endcase
  end

  // Read-modify-write keeps the unaddressed bytes of the register intact.
  assign merged   = (rd_word & ~wr_mask) | (wr_shift & wr_mask);
  assign rd_shift = rd_word >> {bus.i_addr[1:0], 3'b000};

  always_comb begin
    load_data = rd_shift;
    case (bus.i_size)
      SZ_BYTE: load_data = bus.i_unsigned ? {24'h0, rd_shift[7:0]}
                                          : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_data = bus.i_unsigned ? {16'h0, rd_shift[15:0]}
                                          : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= i_io_sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      for (int k = 0; k < 8; k++) hex_q[k] <= 7'h00;
    end else if (accept && bus.i_wren && !err) begin
      case (word_off)
        OFF_LEDR:  ledr_q <= merged[LEDR_W-1:0];
        OFF_LEDG:  ledg_q <= merged[LEDG_W-1:0];
        OFF_HEXLO: for (int k = 0; k < 4; k++) hex_q[k]   <= merged[8*k +: 7] & HEX_MASK;
        OFF_HEXHI: for (int k = 0; k < 4; k++) hex_q[k+4] <= merged[8*k +: 7] & HEX_MASK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_rdata_q <= (err || bus.i_wren) ? 32'h0 : load_data;
        rsp_err_q   <= err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (bus.i_rsp_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_rsp_valid = (state_q == RESP);
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign o_io_ledr       = ledr_q;
  assign o_io_ledg       = ledg_q;

  for (genvar g = 0; g < 8; g++) begin : g_hex
`ifdef IO_HEX_DECODE_EN
    hex_decoder u_dec (.nib(hex_q[g][3:0]), .seg(hex_pins[g]));
`else
    assign hex_pins[g] = hex_q[g];
`endif
  end

  assign o_io_hex0 = hex_pins[0];
  assign o_io_hex1 = hex_pins[1];
  assign o_io_hex2 = hex_pins[2];
  assign o_io_hex3 = hex_pins[3];
  assign o_io_hex4 = hex_pins[4];
  assign o_io_hex5 = hex_pins[5];
  assign o_io_hex6 = hex_pins[6];
  assign o_io_hex7 = hex_pins[7];

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed cases plus randomized traffic against a
// byte-addressed model of the I/O window.
module tb_io_responder;

`ifdef IO_HEX_DECODE_EN
  localparam logic [7:0] HEXM = 8'h0F;
`else
  localparam logic [7:0] HEXM = 8'h7F;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [16:0] i_io_sw = 17'h0;
  wire  [16:0] o_io_ledr;
  wire  [7:0]  o_io_ledg;
  wire  [6:0]  hexw [8];

  io_responder_if bus ();

  io_responder dut (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus), .i_io_sw(i_io_sw),
    .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
    .o_io_hex0(hexw[0]), .o_io_hex1(hexw[1]), .o_io_hex2(hexw[2]), .o_io_hex3(hexw[3]),
    .o_io_hex4(hexw[4]), .o_io_hex5(hexw[5]), .o_io_hex6(hexw[6]), .o_io_hex7(hexw[7])
  );

  always #5 i_clk = ~i_clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mem [0:4095];
  logic [16:0] sw_mdl = 17'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bmask(input logic [11:0] o);
    if (o == 12'h000 || o == 12'h001 || o == 12'h010) return 8'hFF;
    if (o == 12'h002) return 8'h01;
    if (o >= 12'h020 && o <= 12'h027) return HEXM;
    return 8'h00;
  endfunction

  function automatic logic [7:0] rbyte(input logic [11:0] o);
    logic [31:0] s;
    s = 32'(sw_mdl);
    if (o >= 12'h800 && o <= 12'h803) return s[8*int'(o - 12'h800) +: 8];
    return mem[o];
  endfunction

  function automatic logic [6:0] exp_hex(input logic [7:0] b);
`ifdef IO_HEX_DECODE_EN
    case (b[3:0])
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
`else
    return b[6:0];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  // Byte-lane view of the window: a store writes nbytes bytes, a load gathers and extends them.
  task automatic model_access(input logic [31:0] addr, input logic wren, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              output logic [31:0] rd, output logic err);
    logic [11:0] off, wo;
    int          nb;
    logic [31:0] val;
    off = addr[11:0];
    wo  = {off[11:2], 2'b00};
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (addr[31:12] != 20'h10000) ||
          !(wo == 12'h000 || wo == 12'h010 || wo == 12'h020 || wo == 12'h024 || wo == 12'h800) ||
          (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    rd = 32'h0;
    if (err) return;
    if (wren) begin
      if (wo != 12'h800)
        for (int i = 0; i < nb; i++) mem[off + 12'(i)] = wdata[8*i +: 8] & bmask(off + 12'(i));
    end else begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = rbyte(off + 12'(i));
      if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
      rd = val;
    end
  endtask

  task automatic check_pins();
    check("pin_ledr", 32'(o_io_ledr), 32'({mem[2][0], mem[1], mem[0]}));
    check("pin_ledg", 32'(o_io_ledg), 32'(mem[16]));
    for (int k = 0; k < 8; k++) check($sformatf("pin_hex%0d", k), 32'(hexw[k]), 32'(exp_hex(mem[32+k])));
  endtask

  task automatic do_req(input logic [31:0] addr, input logic wren, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, output logic [31:0] obs);
    logic [31:0] erd;
    logic        eerr;
    @(negedge i_clk);
    bus.i_addr = addr; bus.i_wren = wren; bus.i_wdata = wdata;
    bus.i_size = size; bus.i_unsigned = uns;
    bus.i_req_valid = 1'b1; bus.i_rsp_ready = 1'b1;
    check("req_ready", 32'(bus.o_req_ready), 32'h1);
    @(posedge i_clk);
    model_access(addr, wren, wdata, size, uns, erd, eerr);
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    check("rsp_valid", 32'(bus.o_rsp_valid), 32'h1);
    check("rsp_rdata", bus.o_rsp_rdata, erd);
    check("rsp_err", 32'(bus.o_rsp_err), 32'(eerr));
    check_pins();
    obs = bus.o_rsp_rdata;
  endtask

  task automatic set_sw(input logic [16:0] v);
    @(negedge i_clk);
    i_io_sw = v;
    sw_mdl  = v;
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    logic [31:0] obs, ea, eb, addr;
    logic        eerr;
    logic [1:0]  sz;
    bus.i_req_valid = 1'b0; bus.i_rsp_ready = 1'b0; bus.i_addr = 32'h0; bus.i_wren = 1'b0;
    bus.i_wdata = 32'h0; bus.i_size = 2'b00; bus.i_unsigned = 1'b0;
    model_reset();
    #1;
    check("rst_req_ready", 32'(bus.o_req_ready), 32'h1);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
    check("rst_rdata", bus.o_rsp_rdata, 32'h0);
    check("rst_err", 32'(bus.o_rsp_err), 32'h0);
    check_pins();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;

    do_req(32'h1000_0000, 1'b1, 32'h0001_FFFF, 2'd2, 1'b0, obs);
    do_req(32'h1000_0000, 1'b0, 32'h0, 2'd2, 1'b0, obs);
    check("ledr_word", 32'(o_io_ledr), 32'h1FFFF);
    check("ld_ledr_word", obs, 32'h0001_FFFF);

    do_req(32'h1000_0026, 1'b1, 32'h40, 2'd0, 1'b0, obs);
    do_req(32'h1000_0026, 1'b0, 32'h0, 2'd0, 1'b0, obs);
`ifndef IO_HEX_DECODE_EN
    check("hex6_raw", 32'(hexw[6]), 32'h40);
    check("ld_hex6", obs, 32'h40);
`endif

    set_sw(17'h10000);
    do_req(32'h1000_0800, 1'b0, 32'h0, 2'd1, 1'b0, obs);
    check("sw_half", obs, 32'h0);
    do_req(32'h1000_0800, 1'b0, 32'h0, 2'd2, 1'b1, obs);
    check("sw_word", obs, 32'h0001_0000);

    do_req(32'h1000_0001, 1'b1, 32'hFFFF, 2'd1, 1'b0, obs);
    check("err_half_odd", 32'(bus.o_rsp_err), 32'h1);
    do_req(32'h2000_0000, 1'b0, 32'h0, 2'd2, 1'b0, obs);
    check("err_base", 32'(bus.o_rsp_err), 32'h1);
    check("err_no_change", 32'(o_io_ledr), 32'h1FFFF);

    // Back-to-back: response A held while B waits, B accepted in the cycle ready rises.
    @(negedge i_clk);
    bus.i_addr = 32'h1000_0000; bus.i_wren = 1'b0; bus.i_size = 2'd2; bus.i_unsigned = 1'b0;
    bus.i_req_valid = 1'b1; bus.i_rsp_ready = 1'b0;
    @(posedge i_clk);
    model_access(32'h1000_0000, 1'b0, 32'h0, 2'd2, 1'b0, ea, eerr);
    @(negedge i_clk);
    bus.i_addr = 32'h1000_0010; bus.i_wren = 1'b1; bus.i_wdata = 32'hA5; bus.i_size = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check("b2b_req_ready", 32'(bus.o_req_ready), 32'h0);
      check("b2b_hold_valid", 32'(bus.o_rsp_valid), 32'h1);
      check("b2b_hold_rdata", bus.o_rsp_rdata, ea);
      @(negedge i_clk);
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    check("b2b_ready_rise", 32'(bus.o_req_ready), 32'h1);
    @(posedge i_clk);
    model_access(32'h1000_0010, 1'b1, 32'hA5, 2'd0, 1'b0, eb, eerr);
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    check("b2b_valid_b", 32'(bus.o_rsp_valid), 32'h1);
    check("b2b_rdata_b", bus.o_rsp_rdata, eb);
    check("b2b_ledg", 32'(o_io_ledg), 32'hA5);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) set_sw(17'($urandom));
      case ($urandom_range(0, 4))
        0:       addr[11:0] = 12'($urandom_range(0, 3));
        1:       addr[11:0] = 12'h010 + 12'($urandom_range(0, 3));
        2:       addr[11:0] = 12'h020 + 12'($urandom_range(0, 7));
        3:       addr[11:0] = 12'h800 + 12'($urandom_range(0, 3));
        default: addr[11:0] = 12'($urandom);
      endcase
      addr[31:12] = ($urandom_range(0, 15) == 0) ? 20'($urandom) : 20'h10000;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(addr, 1'($urandom), $urandom, sz, 1'($urandom), obs);
    end

    // Reset with a response outstanding.
    do_req(32'h1000_0000, 1'b1, 32'h0000_1234, 2'd2, 1'b0, obs);
    i_reset = 1'b1;
    #1;
    model_reset();
    check("arst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
    check("arst_req_ready", 32'(bus.o_req_ready), 32'h1);
    check("arst_rdata", bus.o_rsp_rdata, 32'h0);
    check("arst_err", 32'(bus.o_rsp_err), 32'h0);
    check_pins();
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    do_req(32'h1000_0800, 1'b0, 32'h0, 2'd2, 1'b1, obs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped I/O responder on the LSU side of the core's data bus. It accepts load/store requests through a valid/ready handshake, decodes a 4 KiB I/O window, and updates the LED and seven-segment output registers. It samples the switch inputs through a synchronizer and returns registered, size-extended load data with a one-cycle response latency. It is the target end of the core's data-memory interface and drives the board-level LEDR/LEDG/HEX/SW pins.

## Interface
- IO_BASE, 32'h1000_0000, window base; only addr[31:12] is compared.
- LEDR_W, 17, width of the red LED register.
- LEDG_W, 8, width of the green LED register.
- SW_W, 17, width of the switch input.
- i_clk  in  1  clock
- i_reset  in  1  reset; i_reset, asynchronous, active-high; clock i_clk
- i_req_valid  in  1  request present
- o_req_ready  out  1  request can be accepted
- i_addr  in  32  byte address
- i_wren  in  1  1 = store, 0 = load
- i_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- i_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_unsigned  in  1  load zero-extend (1) or sign-extend (0)
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  32  load result (0 for stores)
- o_rsp_err  out  1  access error
- i_io_sw  in  SW_W  raw switch pins
- o_io_ledr  out  LEDR_W  red LEDs
- o_io_ledg  out  LEDG_W  green LEDs
- o_io_hex0..o_io_hex7  out  7 each  segment drive, active-low

## Operation
- Register map (offset = addr[11:0]):
  - 0x000 LEDR, rw.
  - 0x010 LEDG, rw.
  - 0x020 HEXLO: byte k = digit k, k = 0..3.
  - 0x024 HEXHI: byte k = digit k+4.
  - 0x800 SW, read-only.
  - Unimplemented bits read 0; bit 7 of each hex byte is not stored.
- Accept condition: i_req_valid && o_req_ready. o_req_ready = (state == IDLE) || i_rsp_ready.
- FSM:
  - IDLE: on accept -> RESP.
  - RESP: if i_rsp_ready and no new accept -> IDLE. If i_rsp_ready and a new accept occurs -> stay in RESP with the new response (back-to-back). Otherwise hold, with rdata/err stable.
- Error conditions: addr[31:12] != IO_BASE[31:12], unmapped offset, i_size = 11, half at an odd address, or word with addr[1:0] != 0.
  - On error: no register changes, o_rsp_rdata = 0, o_rsp_err = 1.
- Store:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Only addressed bytes are written; other bytes keep their values.
  - Stores to SW are ignored, with err = 0.
- Load:
  - Read the full 32-bit register, shift the addressed lane to bit 0, then sign- or zero-extend per i_size/i_unsigned.
  - SW reads the synchronized value, not the raw pins.

## Timing
- Reset values:
  - state IDLE; o_req_ready = 1; o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0.
  - LEDR, LEDG, and HEX registers = 0; synchronizer flops = 0.
  - o_io_hexN = register bits [6:0] (7'h00) without the macro, 7'b1000000 ("0") with it.
- Request accepted at edge N:
  - Register write visible on the pins after edge N.
  - o_rsp_valid high from edge N until the edge where i_rsp_ready = 1.
- Switch synchronizer: two flops. A change on i_io_sw before edge M is readable by requests accepted at edge M+2 or later.
- Load at the same offset immediately after a store: returns the new value (the write completes before the next accept).
- Reset asserted mid-transaction: the pending response is dropped and o_rsp_valid falls asynchronously.

## Configuration
- IO_HEX_DECODE_EN defined:
  - Each HEX byte stores only a nibble in [3:0]; [7:4] read 0.
  - The pin value is the active-low 7-segment decode of the nibble, 0-F.
- Undefined: HEX bytes store raw segments [6:0], driven directly.

## Structure
- Package io_pkg holds:
  - offset localparams for LEDR, LEDG, HEXLO, HEXHI, SW;
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state enum (IDLE, RESP);
  - the 16-entry segment lookup constant.
- Sub-module hex_decoder: nibble in, 7-bit active-low segments out. Instantiated eight times only under IO_HEX_DECODE_EN.

## Test plan
- Word store 0x0001_FFFF to 0x1000_0000, then load: o_io_ledr = 17'h1FFFF; rdata = 0x0001_FFFF, err = 0.
- Byte store 0x40 to 0x1000_0026, then signed-byte load of the same address:
  - o_io_hex6 = 7'h40 (macro off);
  - rdata = 0x0000_0040;
  - other digits unchanged.
- Hold i_io_sw = 17'h10000 for 3 cycles, then signed-half load at 0x1000_0800 -> rdata = 0x0000_0000. Unsigned word load -> 0x0001_0000.
- Half store at 0x1000_0001, and any load from 0x2000_0000 -> err = 1, rdata = 0, no register changes.
- Back-to-back requests with i_rsp_ready held low for 3 cycles:
  - o_req_ready = 0 and the response is held stable;
  - when ready rises, the next request is accepted in the same cycle.
- Assert i_reset while o_rsp_valid = 1 -> valid clears immediately and all outputs return to their reset values.
